cacheline_burst_adaptor: RTL and testbench
==========================================

Name: cacheline_burst_adaptor

Overview:
- Memory-side stage directly upstream of the instruction-cache datapath. It produces the 256-bit refill line consumed as pmem_rdata, and accepts the line address from pmem_address.
- Converts one cache-line read or write request into a burst of 64-bit beats on the physical memory bus.
- Also serves write-back lines for the data cache, so it supports both directions.
- Holds one transaction at a time.

Parameters:
- s_offset, 5, line offset bits; line = 2**s_offset bytes (256 bits).
- s_beat, 64, memory bus beat width in bits; N_BEATS = 256/s_beat = 4.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- line_addr_i  in  32  cache-side line address; low s_offset bits ignored.
- line_read_i  in  1  cache requests a line fill; held high until line_resp_o.
- line_write_i  in  1  cache requests a line write-back; held high until line_resp_o.
- line_wdata_i  in  256  (cacheline_t) write-back line.
- line_rdata_o  out  256  (cacheline_t) assembled fill line.
- line_resp_o  out  1  one-cycle completion pulse.
- pmem_address_o  out  32  burst address, {addr[31:s_offset], s_offset'b0}.
- pmem_read_o  out  1  burst read request.
- pmem_write_o  out  1  burst write request.
- pmem_wdata_o  out  64  current write beat.
- pmem_rdata_i  in  64  current read beat.
- pmem_resp_i  in  1  beat accepted (write) or beat valid (read).

Behaviour:
- Reset (async, immediate):
  - state = IDLE, beat counter = 0.
  - pmem_read_o, pmem_write_o and line_resp_o = 0.
  - pmem_address_o, pmem_wdata_o and line_rdata_o = 0.
- State machine states: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - On line_write_i: latch address and line_wdata_i, go to WR_BURST.
  - Else on line_read_i: latch address, go to RD_BURST.
  - If both are high, write wins; the read is taken later from IDLE.
  - pmem_resp_i is ignored in this state.
- Request timing:
  - pmem_read_o/pmem_write_o are asserted from the cycle after acceptance.
  - They are driven by state, not combinationally from the cache inputs.
  - pmem_address_o is registered at acceptance and stays stable for the whole burst.
- RD_BURST:
  - pmem_read_o = 1.
  - Each cycle with pmem_resp_i: write pmem_rdata_i into line_rdata_o[s_beat*cnt +: s_beat], then cnt++.
  - Beat 0 maps to bits 63:0.
  - Gaps (pmem_resp_i = 0) stall without side effects.
  - On the beat with cnt = N_BEATS-1: go to RD_DONE and clear cnt to 0.
- RD_DONE:
  - pmem_read_o = 0, line_resp_o = 1 for exactly one cycle.
  - line_rdata_o holds the complete line; it then holds until the next read burst starts overwriting it.
  - Next state is IDLE.
- WR_BURST:
  - pmem_write_o = 1.
  - pmem_wdata_o = latched_line[s_beat*cnt +: s_beat], combinational from the counter.
  - cnt advances on pmem_resp_i; the last beat goes to WR_DONE.
- WR_DONE: line_resp_o = 1 for one cycle, then IDLE.
- Request edges:
  - Requests present during a DONE cycle are not accepted; the cache drops its request on line_resp_o.
  - Minimum turnaround between bursts is one IDLE cycle.
- Latency: with no memory stalls, a fill takes 1 (accept) + 4 (beats) + 1 (resp) cycles.
- Counter: 2-bit ($clog2(N_BEATS)), wraps only via the explicit clear; never wraps mid-burst.
- Reset mid-burst:
  - Abandons the transaction; no line_resp_o.
  - line_rdata_o is cleared, including any partial beats.
- Changes to line_addr_i or line_wdata_i after acceptance have no effect.

Decomposition:
- cacheline_t (256-bit) stays in the shared rv32i_types package. Add to that package:
  - constants for beat width and beat count;
  - an adaptor_state_t enum.
- No sub-module needed; a single FSM+datapath module.

Test Plan:
- Read, no stalls: line_read_i with addr 0x8000_0124; beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on 4 consecutive resp cycles.
  - pmem_address_o = 0x8000_0120.
  - line_resp_o pulses exactly at cycle 6.
  - line_rdata_o = {0x4444…, 0x3333…, 0x2222…, 0x1111…}.
- Read with stalls: pmem_resp_i pattern 1,0,0,1,1,0,1.
  - Line is assembled in correct order.
  - line_resp_o fires one cycle after the 4th accepted beat.
  - Exactly one pulse.
- Write burst: line_wdata_i = 256'hDDDD…CCCC…BBBB…AAAA (64-bit lanes).
  - pmem_wdata_o = AAAA…, BBBB…, CCCC…, DDDD… on successive resp cycles.
  - pmem_write_o drops after the 4th beat; line_resp_o pulses once.
- Write-back then refill: line_write_i and line_read_i asserted together.
  - Write burst completes first, then IDLE, then read burst to the same latched read address.
  - Two separate resp pulses.
- Reset mid-burst: rst asserted after beat 2 of a read.
  - pmem_read_o, line_resp_o and line_rdata_o go to 0 immediately (asynchronously).
  - A following read completes normally.
- Spurious pmem_resp_i in IDLE for 3 cycles: no state change, no line_resp_o.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I type package: cache line type plus the constants and state
// encoding used by the cache-line to memory-burst adaptor.
package rv32i_types;

  localparam int S_OFFSET = 5;
  localparam int S_LINE   = 8 * (2 ** S_OFFSET);
  localparam int S_BEAT   = 64;
  localparam int N_BEATS  = S_LINE / S_BEAT;
  localparam int CNT_W    = $clog2(N_BEATS);

  typedef logic [S_LINE-1:0] cacheline_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Converts one 256-bit cache-line read or write-back into a burst of 64-bit
// beats on the physical memory bus; one transaction in flight at a time.
module cacheline_burst_adaptor
  import rv32i_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  line_addr_i,
  input  logic         line_read_i,
  input  logic         line_write_i,
  input  logic [255:0] line_wdata_i,
  output logic [255:0] line_rdata_o,
  output logic         line_resp_o,
  output logic [31:0]  pmem_address_o,
  output logic         pmem_read_o,
  output logic         pmem_write_o,
  output logic [63:0]  pmem_wdata_o,
  input  logic [63:0]  pmem_rdata_i,
  input  logic         pmem_resp_i
);

  localparam logic [31:0]      ADDR_MASK = ~((32'd1 << S_OFFSET) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  adaptor_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [255:0]     wline;

  // Write beats come straight from the latched line so the bus sees the new
  // beat in the same cycle the counter advances.
  always_comb begin
    pmem_wdata_o = wline[S_BEAT*int'(cnt) +: S_BEAT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      wline          <= '0;
      line_rdata_o   <= '0;
      line_resp_o    <= 1'b0;
      pmem_address_o <= '0;
      pmem_read_o    <= 1'b0;
      pmem_write_o   <= 1'b0;
    end else begin
      line_resp_o <= 1'b0;
      case (state)
        IDLE: begin
          if (line_write_i) begin
            pmem_address_o <= line_addr_i & ADDR_MASK;
            wline          <= line_wdata_i;
            pmem_write_o   <= 1'b1;
            state          <= WR_BURST;
          end else if (line_read_i) begin
            pmem_address_o <= line_addr_i & ADDR_MASK;
            pmem_read_o    <= 1'b1;
            state          <= RD_BURST;
          end
        end

        RD_BURST: begin
          if (pmem_resp_i) begin
            line_rdata_o[S_BEAT*int'(cnt) +: S_BEAT] <= pmem_rdata_i;
            if (cnt == LAST_BEAT) begin
              cnt         <= '0;
              pmem_read_o <= 1'b0;
              line_resp_o <= 1'b1;
              state       <= RD_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        // Completion cycles deliberately ignore new requests, which forces
        // at least one IDLE cycle between bursts.
        RD_DONE: begin
          state <= IDLE;
        end

        WR_BURST: begin
          if (pmem_resp_i) begin
            if (cnt == LAST_BEAT) begin
              cnt          <= '0;
              pmem_write_o <= 1'b0;
              line_resp_o  <= 1'b1;
              state        <= WR_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        WR_DONE: begin
          state <= IDLE;
        end

        default: begin
          state        <= IDLE;
          cnt          <= '0;
          pmem_read_o  <= 1'b0;
          pmem_write_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench for cacheline_burst_adaptor: stimulus pushes expected lines,
// beats and completions; a negedge monitor pops and compares them.
module tb_cacheline_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [31:0]  line_addr_i;
  logic         line_read_i;
  logic         line_write_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  pmem_address_o;
  logic         pmem_read_o;
  logic         pmem_write_o;
  logic [63:0]  pmem_wdata_o;
  logic [63:0]  pmem_rdata_i;
  logic         pmem_resp_i;

  cacheline_burst_adaptor dut (
    .clk            (clk),
    .rst            (rst),
    .line_addr_i    (line_addr_i),
    .line_read_i    (line_read_i),
    .line_write_i   (line_write_i),
    .line_wdata_i   (line_wdata_i),
    .line_rdata_o   (line_rdata_o),
    .line_resp_o    (line_resp_o),
    .pmem_address_o (pmem_address_o),
    .pmem_read_o    (pmem_read_o),
    .pmem_write_o   (pmem_write_o),
    .pmem_wdata_o   (pmem_wdata_o),
    .pmem_rdata_i   (pmem_rdata_i),
    .pmem_resp_i    (pmem_resp_i)
  );

  int errors = 0;
  int checks = 0;
  int resp_count = 0;
  int exp_resp_total = 0;

  bit           exp_kind[$];
  logic [255:0] exp_line[$];
  logic [63:0]  exp_wbeat[$];
  logic [31:0]  exp_addr;
  logic [63:0]  rd_beats[4];
  logic [255:0] last_line;
  bit           pat[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  // Monitor: compares every beat and completion against the scoreboard.
  always @(negedge clk) begin : monitor
    bit           k;
    logic [255:0] l;
    logic [63:0]  w;
    if (!rst) begin
      if (pmem_read_o || pmem_write_o)
        check_output("req_exclusive", 256'(pmem_read_o & pmem_write_o), 256'(0));
      if ((pmem_read_o || pmem_write_o) && pmem_resp_i)
        check_output("burst_address", 256'(pmem_address_o), 256'(exp_addr));
      if (pmem_write_o && pmem_resp_i) begin
        if (exp_wbeat.size() == 0) begin
          check_output("unexpected_wbeat", 256'(1), 256'(0));
        end else begin
          w = exp_wbeat.pop_front();
          check_output("write_beat", 256'(pmem_wdata_o), 256'(w));
        end
      end
      if (line_resp_o) begin
        resp_count++;
        if (exp_kind.size() == 0) begin
          check_output("unexpected_resp", 256'(1), 256'(0));
        end else begin
          k = exp_kind.pop_front();
          check_output("resp_req_dropped", 256'(pmem_read_o | pmem_write_o), 256'(0));
          if (k) begin
            l = exp_line.pop_front();
            check_output("read_line", line_rdata_o, l);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Read transaction; exp_edges < 0 skips the latency and timing checks.
  task automatic read_txn(input logic [31:0] addr, input int exp_edges);
    int edges;
    int b;
    exp_kind.push_back(1'b1);
    exp_line.push_back({rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
    last_line = {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
    exp_addr = addr & 32'hFFFF_FFE0;
    exp_resp_total++;
    line_addr_i = addr;
    line_read_i = 1'b1;
    if (exp_edges >= 0) begin
      #1;
      check_output("read_not_comb", 256'(pmem_read_o), 256'(0));
    end
    edges = 0;
    while (!pmem_read_o && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!pmem_read_o) begin
      check_output("read_start_timeout", 256'(pmem_read_o), 256'(1));
      line_read_i = 1'b0;
      return;
    end
    check_output("read_address", 256'(pmem_address_o), 256'(exp_addr));
    b = 0;
    for (int i = 0; i < pat.size(); i++) begin
      pmem_resp_i  = pat[i];
      pmem_rdata_i = pat[i] ? rd_beats[b] : 64'hDEAD_BEEF_DEAD_BEEF;
      line_addr_i  = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      edges++;
      if (pat[i]) b++;
    end
    pmem_resp_i  = 1'b0;
    pmem_rdata_i = 64'h0;
    check_output("read_resp_timing", 256'(line_resp_o), 256'(1));
    if (exp_edges >= 0)
      check_output("read_latency", 256'(edges), 256'(exp_edges));
    line_read_i = 1'b0;
    @(posedge clk);
    #1;
    check_output("read_resp_one_cycle", 256'(line_resp_o), 256'(0));
    check_output("read_resp_count", 256'(resp_count), 256'(exp_resp_total));
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [255:0] line,
                           input int exp_edges);
    int edges;
    exp_kind.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_wbeat.push_back(line[64*i +: 64]);
    exp_addr = addr & 32'hFFFF_FFE0;
    exp_resp_total++;
    line_addr_i  = addr;
    line_wdata_i = line;
    line_write_i = 1'b1;
    edges = 0;
    while (!pmem_write_o && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!pmem_write_o) begin
      check_output("write_start_timeout", 256'(pmem_write_o), 256'(1));
      line_write_i = 1'b0;
      return;
    end
    line_wdata_i = ~line;
    line_addr_i  = ~addr;
    for (int i = 0; i < pat.size(); i++) begin
      pmem_resp_i = pat[i];
      @(posedge clk);
      #1;
      edges++;
    end
    pmem_resp_i = 1'b0;
    check_output("write_resp_timing", 256'(line_resp_o), 256'(1));
    check_output("write_req_dropped", 256'(pmem_write_o), 256'(0));
    if (exp_edges >= 0)
      check_output("write_latency", 256'(edges), 256'(exp_edges));
    line_write_i = 1'b0;
    @(posedge clk);
    #1;
    check_output("write_resp_count", 256'(resp_count), 256'(exp_resp_total));
  endtask

  task automatic apply_stimulus();
    // Reset state
    rst = 1'b1;
    line_addr_i = '0; line_read_i = 1'b0; line_write_i = 1'b0;
    line_wdata_i = '0; pmem_rdata_i = '0; pmem_resp_i = 1'b0;
    exp_addr = '0; last_line = '0;
    idle(2);
    check_output("rst_pmem_read", 256'(pmem_read_o), 256'(0));
    check_output("rst_pmem_write", 256'(pmem_write_o), 256'(0));
    check_output("rst_line_resp", 256'(line_resp_o), 256'(0));
    check_output("rst_address", 256'(pmem_address_o), 256'(0));
    check_output("rst_wdata", 256'(pmem_wdata_o), 256'(0));
    check_output("rst_rdata", line_rdata_o, 256'(0));
    rst = 1'b0;
    idle(2);

    // Read, no stalls: response visible after 5 edges (6th cycle)
    rd_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    pat = '{1, 1, 1, 1};
    read_txn(32'h8000_0124, 5);
    check_output("read_addr_const", 256'(exp_addr), 256'(32'h8000_0120));
    idle(1);

    // Read with gaps between beats
    rd_beats = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    pat = '{1, 0, 0, 1, 1, 0, 1};
    read_txn(32'h0000_105C, 8);
    idle(1);

    // Write burst, then a stalled write burst
    pat = '{1, 1, 1, 1};
    write_txn(32'h2000_0000, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 5);
    idle(1);
    pat = '{0, 1, 1, 0, 1, 1};
    write_txn(32'h2000_0047, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                              64'h0F0F_0F0F_F0F0_F0F0, 64'hA5A5_5A5A_A5A5_5A5A}, 7);
    idle(1);
    check_output("rdata_held_after_write", line_rdata_o, last_line);

    // Simultaneous write-back and refill: write wins, read follows
    line_read_i = 1'b1;
    pat = '{1, 1, 1, 1};
    write_txn(32'h3000_0060, {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                              64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001}, 5);
    rd_beats = '{64'h9999_9999_9999_9999, 64'hAAAA_0000_AAAA_0000,
                 64'hBBBB_0000_BBBB_0000, 64'hCCCC_0000_CCCC_0000};
    read_txn(32'h3000_0060, -1);
    idle(1);

    // Reset after two beats of a read
    rd_beats = '{64'hE1E1_E1E1_E1E1_E1E1, 64'hE2E2_E2E2_E2E2_E2E2,
                 64'hE3E3_E3E3_E3E3_E3E3, 64'hE4E4_E4E4_E4E4_E4E4};
    exp_addr = 32'h4000_0080;
    line_addr_i = 32'h4000_0080;
    line_read_i = 1'b1;
    idle(1);
    check_output("rst_test_read_started", 256'(pmem_read_o), 256'(1));
    for (int i = 0; i < 2; i++) begin
      pmem_resp_i  = 1'b1;
      pmem_rdata_i = rd_beats[i];
      idle(1);
    end
    pmem_resp_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_output("midrst_pmem_read", 256'(pmem_read_o), 256'(0));
    check_output("midrst_line_resp", 256'(line_resp_o), 256'(0));
    check_output("midrst_rdata", line_rdata_o, 256'(0));
    line_read_i = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(1);
    pat = '{1, 1, 1, 1};
    read_txn(32'h4000_0080, 5);
    idle(1);

    // Spurious memory responses while idle
    pmem_rdata_i = 64'hBADC_0FFE_BADC_0FFE;
    pmem_resp_i  = 1'b1;
    idle(3);
    pmem_resp_i  = 1'b0;
    check_output("spurious_no_read", 256'(pmem_read_o), 256'(0));
    check_output("spurious_no_write", 256'(pmem_write_o), 256'(0));
    check_output("spurious_rdata_held", line_rdata_o, last_line);
    check_output("spurious_resp_count", 256'(resp_count), 256'(exp_resp_total));
    rd_beats = '{64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                 64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738};
    read_txn(32'h7FFF_FFE1, 5);
    idle(3);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    apply_stimulus();
    check_output("final_resp_count", 256'(resp_count), 256'(exp_resp_total));
    check_output("final_resp_queue", 256'(exp_kind.size()), 256'(0));
    check_output("final_wbeat_queue", 256'(exp_wbeat.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
